instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Instruction-issuing front end for the 16-bit processor. Drives the processor's 16-bit instruction input (iin) from a small loadable program buffer.
- Holds each instruction stable for a fixed number of clocks, then advances to the next.
- Replaces hand-timed instruction stimulus with a synthesizable program source. A host or boot logic fills the buffer, pulses start, and waits for done.

Parameters:
- DEPTH, 16, number of program words in the buffer (power of two).
- ADDR_W, 4, buffer address width (log2 DEPTH).
- HOLD_CYCLES, 4, clocks each instruction is held on iin (minimum 1).

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- wr_en  input  1  buffer write strobe.
- wr_addr  input  ADDR_W  buffer write address.
- wr_data  input  16  instruction word to store.
- prog_len  input  ADDR_W+1  number of instructions to issue (0..DEPTH); sampled on start.
- start  input  1  begin issuing from address 0.
- abort  input  1  stop issuing immediately.
- iin  output  16  instruction to processor.
- iin_valid  output  1  high while iin carries a program instruction.
- pc  output  ADDR_W  address of instruction currently on iin.
- busy  output  1  high in ISSUE state.
- done  output  1  one-cycle pulse after last instruction's hold completes.

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE; iin=16'h0000; iin_valid=0; pc=0; busy=0; done=0; hold counter=0; latched length=0.
  - Buffer contents are not reset.
- Buffer writes:
  - Synchronous write of wr_data to mem[wr_addr] when wr_en=1 and state≠ISSUE.
  - Writes during ISSUE are ignored.
  - The buffer read is combinational into the iin register.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - start=1, abort=0, prog_len>0: latch len=prog_len; pc←0; iin←mem[0]; iin_valid←1; cnt←HOLD_CYCLES-1; go to ISSUE.
  - All registered, so iin is valid from the cycle after start is sampled.
  - start with prog_len=0: go to DONE with iin_valid=0.
  - prog_len>DEPTH is saturated to DEPTH.
- ISSUE:
  - cnt≠0: cnt←cnt-1; iin held.
  - cnt=0 and pc≠len-1: pc←pc+1; iin←mem[pc+1]; cnt←HOLD_CYCLES-1.
  - cnt=0 and pc=len-1: iin←0; iin_valid←0; go to DONE.
  - Each instruction is therefore on iin for exactly HOLD_CYCLES cycles, with no gap between instructions.
  - start is ignored while in ISSUE.
- DONE:
  - done=1 for exactly this one cycle; then go to IDLE. pc retains last value.
  - start in the DONE cycle is ignored.
- abort:
  - Has priority over start and over all transitions, in any state.
  - Next edge: state=IDLE; iin=0; iin_valid=0; cnt=0; no done pulse.
- Reset mid-ISSUE: outputs drop immediately to reset values (asynchronous); a new start is required afterwards.
- busy = (state==ISSUE), registered alongside state.

Test Plan:
- Reset then load mem[0..3]={A01C, A40A, 2080, 8000}, prog_len=4, HOLD_CYCLES=4, pulse start:
  - iin shows A01C, A40A, 2080, 8000, each for exactly 4 cycles, iin_valid high for 16 consecutive cycles.
  - Then done pulses 1 cycle, iin=0, busy=0.
- prog_len=1, mem[0]=A01C, start → iin=A01C for 4 cycles, pc=0, done on the 5th cycle after start.
- prog_len=0, start → no iin_valid, done pulses on the cycle after start, back in IDLE next cycle.
- During issue of the program above, assert abort on the 6th valid cycle:
  - Next edge gives iin_valid=0, iin=0, busy=0, no done.
  - A subsequent start replays from pc=0.
- During ISSUE, wr_en to mem[2]=FFFF → write ignored, third issued word still 2080. After done, the same write succeeds and a rerun issues FFFF third.
- Deassert resetn asynchronously mid-ISSUE (between edges) → iin, iin_valid, busy, pc clear immediately. Buffer contents preserved: rerun without reload reproduces the original sequence.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: loadable program buffer that drives each instruction onto iin
// for HOLD_CYCLES clocks, with start/abort control and a one-cycle done pulse.
module instr_sequencer #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              abort,
    output logic [15:0]       iin,
    output logic              iin_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    state_t            r_state;
    logic [15:0]       r_mem [DEPTH];
    logic [15:0]       r_iin;
    logic              r_valid;
    logic [ADDR_W-1:0] r_pc;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   w_len_sat;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_last;

    assign w_len_sat = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
    assign w_pc_next = r_pc + 1'b1;
    assign w_last    = ({1'b0, r_pc} == r_len - 1'b1);

    assign iin       = r_iin;
    assign iin_valid = r_valid;
    assign pc        = r_pc;
    assign busy      = r_busy;
    assign done      = r_done;

    // Buffer is deliberately not reset so a program survives a mid-run reset.
    always_ff @(posedge clock) begin
        if (wr_en && r_state != S_ISSUE) r_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_iin   <= '0;
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_len   <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_iin   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_len_sat != '0) begin
                        r_len   <= w_len_sat;
                        r_pc    <= '0;
                        r_iin   <= r_mem['0];
                        r_valid <= 1'b1;
                        r_cnt   <= CNT_MAX;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end else if (start) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_ISSUE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!w_last) begin
                        r_pc  <= w_pc_next;
                        r_iin <= r_mem[w_pc_next];
                        r_cnt <= CNT_MAX;
                    end else begin
                        r_iin   <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized checks of instr_sequencer against a trace model
// that expands each program word into HOLD_CYCLES expected cycles.
module tb_instr_sequencer;
    localparam int DEPTH = 16;
    localparam int H     = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [4:0]  prog_len = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] iin;
    logic        iin_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass = 0;
    logic [15:0] mem_m [DEPTH];
    logic [15:0] exp_w [$];
    int          exp_p [$];

    instr_sequencer #(.DEPTH(DEPTH), .ADDR_W(4), .HOLD_CYCLES(H)) dut (
        .clock(clock), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .prog_len(prog_len), .start(start), .abort(abort),
        .iin(iin), .iin_valid(iin_valid), .pc(pc), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic build_trace(input int len);
        int n;
        n = (len > DEPTH) ? DEPTH : len;
        exp_w.delete();
        exp_p.delete();
        for (int i = 0; i < n; i++)
            for (int h = 0; h < H; h++) begin
                exp_w.push_back(mem_m[i]);
                exp_p.push_back(i);
            end
    endtask

    task automatic write_word(input int a, input logic [15:0] d);
        @(negedge clock);
        wr_en = 1'b1; wr_addr = a[3:0]; wr_data = d;
        @(posedge clock);
        #1 wr_en = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic pulse_start(input int len);
        @(negedge clock);
        prog_len = len[4:0]; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({iin, iin_valid, pc, busy, done} !== 23'd0)
            $display("FAIL reset: got iin=%h v=%b pc=%0d busy=%b done=%b, want all zero", iin, iin_valid, pc, busy, done);
        else n_pass++;
        @(negedge clock) resetn = 1'b1;
    endtask

    // Runs one program; wr_mid attempts a write to mem[2] while issuing.
    task automatic test_issue(input string tag, input int len, input bit wr_mid);
        logic [21:0] want;
        int last_pc;
        build_trace(len);
        last_pc = exp_p.size() ? exp_p[exp_p.size()-1] : int'(pc);
        pulse_start(len);
        for (int k = 0; k < exp_w.size(); k++) begin
            if (wr_mid && k == 1) begin wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hFFFF; end
            if (wr_mid && k == 2) wr_en = 1'b0;
            want = {1'b1, 1'b1, 4'(exp_p[k]), exp_w[k]};
            n_checks++;
            if ({busy, iin_valid, pc, iin} !== want)
                $display("FAIL %s cyc%0d: got busy=%b v=%b pc=%0d iin=%h, want busy=%b v=%b pc=%0d iin=%h",
                         tag, k, busy, iin_valid, pc, iin, want[21], want[20], want[19:16], want[15:0]);
            else n_pass++;
            @(posedge clock); #1;
        end
        n_checks++;
        if ({done, iin_valid, busy, iin, pc} !== {1'b1, 1'b0, 1'b0, 16'h0, 4'(last_pc)})
            $display("FAIL %s done: got done=%b v=%b busy=%b iin=%h pc=%0d, want 1 0 0 0000 pc=%0d",
                     tag, done, iin_valid, busy, iin, pc, last_pc);
        else n_pass++;
        @(posedge clock); #1;
        n_checks++;
        if ({done, busy, iin_valid} !== 3'b000)
            $display("FAIL %s idle: got done=%b busy=%b v=%b, want 000", tag, done, busy, iin_valid);
        else n_pass++;
    endtask

    task automatic test_abort();
        build_trace(4);
        pulse_start(4);
        repeat (5) begin @(posedge clock); #1; end
        n_checks++;
        if ({iin_valid, iin} !== {1'b1, exp_w[5]})
            $display("FAIL abort_pre: got v=%b iin=%h, want 1 %h", iin_valid, iin, exp_w[5]);
        else n_pass++;
        abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if ({iin_valid, iin, busy, done} !== 19'd0)
                $display("FAIL abort cyc%0d: got v=%b iin=%h busy=%b done=%b, want 0", k, iin_valid, iin, busy, done);
            else n_pass++;
            @(posedge clock); #1;
        end
        test_issue("abort_replay", 4, 1'b0);
    endtask

    task automatic test_async_reset();
        pulse_start(4);
        repeat (6) begin @(posedge clock); #1; end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({iin, iin_valid, pc, busy, done} !== 23'd0)
            $display("FAIL async_reset: got iin=%h v=%b pc=%0d busy=%b done=%b, want all zero", iin, iin_valid, pc, busy, done);
        else n_pass++;
        @(negedge clock) resetn = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({iin_valid, busy} !== 2'b00)
            $display("FAIL post_reset_idle: got v=%b busy=%b, want 00", iin_valid, busy);
        else n_pass++;
        test_issue("after_reset", 4, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < 5; w++)
                write_word($urandom_range(0, DEPTH - 1), 16'($urandom));
            test_issue($sformatf("rand%0d", it), $urandom_range(0, 31), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        write_word(0, 16'hA01C);
        write_word(1, 16'hA40A);
        write_word(2, 16'h2080);
        write_word(3, 16'h8000);
        test_issue("prog4", 4, 1'b0);
        test_issue("single", 1, 1'b0);
        test_issue("zero_len", 0, 1'b0);
        test_abort();
        test_issue("wr_ignored", 4, 1'b1);
        write_word(2, 16'hFFFF);
        test_issue("wr_taken", 4, 1'b0);
        test_async_reset();
        for (int a = 4; a < DEPTH; a++) write_word(a, 16'(a * 16'h0111));
        test_issue("saturate", 25, 1'b0);
        test_issue("full", 16, 1'b0);
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
